aes_decrypt: RTL and testbench
==============================

// Module: aes_decrypt
// PURPOSE
// - Iterative AES inverse cipher (FIPS-197 InvCipher), one round per accepted subkey beat.
// - Decryption counterpart of the team's iterative AES encrypt core; shares the same subkey-fetch interface.
// - The external key store serves round keys; this core reads them in reverse order, Nr down to 0.
// - Sits beside the encrypt core in the accelerator top level.
// PARAMETERS
// - None. Widths are fixed by AES: 128-bit block, 4-bit subkey address.
// PORTS
// - clk           in   1    clock
// - reset         in   1    synchronous, active-high reset
// - start         in   1    request decryption; sampled only in IDLE
// - key_len       in   3    one-hot: [0]=AES-128, [1]=AES-192, [2]=AES-256; priority [2]>[1]>[0]; 3'b000 = invalid
// - ciphertext    in   128  input block; byte0 = [127:120], column-major state (FIPS-197 order)
// - subkey        in   128  round key for subkey_addr
// - subkey_valid  in   1    subkey is valid for the current subkey_addr
// - subkey_addr   out  4    round-key index requested
// - plaintext     out  128  result register
// - ready         out  1    level; result in plaintext is valid
// - abort         in   1    present only with AES_DEC_ABORT_EN
// BEHAVIOUR
// - Reset: state=IDLE, plaintext=0, ready=0, subkey_addr=0, round counter=0. Reset wins over all inputs.
// - Nr = 10 / 12 / 14 for AES-128 / 192 / 256.
// - IDLE: start=1 and key_len!=0 -> latch ciphertext, latch Nr, subkey_addr<=Nr, ready<=0, go to INIT.
//   - start with key_len=0 is ignored; ready and plaintext hold.
//   - start outside IDLE is ignored.
// - INIT (subkey_valid=1): state<=ct_latched ^ subkey, rounds_left<=Nr, subkey_addr<=Nr-1, go to ROUND.
// - ROUND (subkey_valid=1): state<=AddRoundKey(InvSubBytes(InvShiftRows(state)), subkey).
//   - InvMixColumns is applied after AddRoundKey when rounds_left!=1 and is skipped on the final round.
//   - rounds_left and subkey_addr each decrement by 1.
//   - When rounds_left==1: plaintext is written, ready<=1, go to IDLE; subkey_addr ends at 0 and wraps to 15 (don't-care).
// - subkey_valid=0 in INIT or ROUND: full stall; state, counters and subkey_addr hold. subkey_addr is stable while waiting.
// - Internal state register is also the plaintext output register.
//   - plaintext shows intermediate values while busy; consumers qualify it with ready.
// - Latency with subkey_valid tied high: ready is seen Nr+1 cycles after the start edge (11 / 13 / 15).
// - ready stays high until the next accepted start or a reset. plaintext holds its value until then.
// - ciphertext may change after the start edge without affecting the result.
// - Combinational datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
//   - InvSubBytes is 16 inverse S-box LUTs. InvMixColumns is GF(2^8) multiply by {0e,0b,0d,09}, modulus x^8+x^4+x^3+x+1.
// - Reset mid-operation returns to IDLE with the reset values above. No partial result is retained.
// CONFIGURATION
// - AES_DEC_ABORT_EN defined:
//   - adds the abort input.
//   - abort=1 in INIT or ROUND -> next edge: IDLE, ready=0, plaintext=0, subkey_addr=0.
//   - abort in IDLE has no effect. abort wins over subkey_valid in the same cycle.
//   - abort and start together in IDLE: start is accepted.
// - AES_DEC_ABORT_EN undefined: no abort port. Operations always run to completion or reset.
// TESTING
// - AES-128, key 000102..0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a, valid tied 1:
//   - plaintext = 00112233445566778899aabbccddeeff.
//   - ready rises 11 cycles after start. subkey_addr sequence is 10,9,...,0.
// - AES-192, key 000102..17, ct dda97ca4864cdfe06eaf70a0ec0d7191:
//   - same plaintext; ready after 13 cycles; first subkey_addr = 12.
// - AES-256, key 000102..1f, ct 8ea2b7ca516745bfeafc49904b496089, subkey_valid random 50%:
//   - same plaintext. subkey_addr holds during every stall.
// - key_len=3'b000 with start=1, and start pulsed mid-run:
//   - both ignored; ready and plaintext unchanged; the in-flight run completes correctly.
// - reset asserted at round 5, then a new AES-128 run:
//   - outputs return to 0 the next cycle; the new run gives the correct plaintext.
// - With AES_DEC_ABORT_EN, abort at round 3:
//   - IDLE next cycle with ready=0 and plaintext=0; a following start decrypts correctly.

Source files
------------

// File: rtl/aes_decrypt_if.sv
// Subkey-fetch and block handshake bundle for the AES inverse cipher.
// The abort signal exists only when AES_DEC_ABORT_EN is defined.
interface aes_decrypt_if;
  logic         start;
  logic [2:0]   key_len;
  logic [127:0] ciphertext;
  logic [127:0] subkey;
  logic         subkey_valid;
  logic [3:0]   subkey_addr;
  logic [127:0] plaintext;
  logic         ready;
`ifdef AES_DEC_ABORT_EN
  logic         abort;

  modport master (
    output start, key_len, ciphertext,
    output subkey, subkey_valid, abort,
    input  subkey_addr, plaintext, ready
  );
  modport slave (
    input  start, key_len, ciphertext,
    input  subkey, subkey_valid, abort,
    output subkey_addr, plaintext, ready
  );
`else
  modport master (
    output start, key_len, ciphertext,
    output subkey, subkey_valid,
    input  subkey_addr, plaintext, ready
  );
  modport slave (
    input  start, key_len, ciphertext,
    input  subkey, subkey_valid,
    output subkey_addr, plaintext, ready
  );
`endif
endinterface

// File: rtl/aes_decrypt.sv
// Iterative AES inverse cipher, one round per accepted subkey beat.
// Optional abort input enabled by AES_DEC_ABORT_EN.
module aes_decrypt (
  input logic          clk,
  input logic          reset,
  aes_decrypt_if.slave bus
);
  typedef enum logic [1:0] {IDLE, INIT, ROUND} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] st_q, st_d;
  logic [127:0] ct_q, ct_d;
  logic [3:0]   nr_q, nr_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [3:0]   addr_q, addr_d;
  logic         rdy_q, rdy_d;
  logic [3:0]   nr_sel;
  logic [127:0] ark, rnd_out;
  logic         abort_w;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Inverse S-box: undo the affine map, then invert as a^254.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b, sq, r;
    b = {s[1:0], s[7:2]} ^ {s[4:0], s[7:5]}
      ^ {s[6:0], s[7]} ^ 8'h05;
    sq = b;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gm(sq, sq);
      r  = gm(r, sq);
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int n = 0; n < 16; n++)
      o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o = '0;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gm(a0, 8'h0e) ^ gm(a1, 8'h0b)
                       ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
      o[119-32*c -: 8] = gm(a0, 8'h09) ^ gm(a1, 8'h0e)
                       ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
      o[111-32*c -: 8] = gm(a0, 8'h0d) ^ gm(a1, 8'h09)
                       ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
      o[103-32*c -: 8] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d)
                       ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
    end
    return o;
  endfunction

`ifdef AES_DEC_ABORT_EN
  assign abort_w = bus.abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    if (bus.key_len[2])      nr_sel = 4'd14;
    else if (bus.key_len[1]) nr_sel = 4'd12;
    else                     nr_sel = 4'd10;
  end

  // Last round skips InvMixColumns.
  assign ark     = inv_sub(inv_shift(st_q)) ^ bus.subkey;
  assign rnd_out = (rnd_q == 4'd1) ? ark : inv_mix(ark);

  always_comb begin
    fsm_d  = fsm_q;
    st_d   = st_q;
    ct_d   = ct_q;
    nr_d   = nr_q;
    rnd_d  = rnd_q;
    addr_d = addr_q;
    rdy_d  = rdy_q;
    if (abort_w && fsm_q != IDLE) begin
      fsm_d  = IDLE;
      st_d   = '0;
      rnd_d  = '0;
      addr_d = '0;
      rdy_d  = 1'b0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (bus.start && |bus.key_len) begin
            ct_d   = bus.ciphertext;
            nr_d   = nr_sel;
            addr_d = nr_sel;
            rdy_d  = 1'b0;
            fsm_d  = INIT;
          end
        end
        INIT: begin
          if (bus.subkey_valid) begin
            st_d   = ct_q ^ bus.subkey;
            rnd_d  = nr_q;
            addr_d = nr_q - 4'd1;
            fsm_d  = ROUND;
          end
        end
        ROUND: begin
          if (bus.subkey_valid) begin
            st_d   = rnd_out;
            rnd_d  = rnd_q - 4'd1;
            addr_d = addr_q - 4'd1;
            if (rnd_q == 4'd1) begin
              rdy_d = 1'b1;
              fsm_d = IDLE;
            end
          end
        end
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q  <= IDLE;
      st_q   <= '0;
      ct_q   <= '0;
      nr_q   <= '0;
      rnd_q  <= '0;
      addr_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      st_q   <= st_d;
      ct_q   <= ct_d;
      nr_q   <= nr_d;
      rnd_q  <= rnd_d;
      addr_q <= addr_d;
      rdy_q  <= rdy_d;
    end
  end

  assign bus.plaintext   = st_q;
  assign bus.ready       = rdy_q;
  assign bus.subkey_addr = addr_q;
endmodule

// File: tb/tb_aes_decrypt.sv
// Scoreboard bench for aes_decrypt: forward-AES reference model,
// key server with random stalls, address-sequence monitor.
module tb_aes_decrypt;
  logic clk = 1'b0;
  logic reset;
  aes_decrypt_if bus();

  aes_decrypt dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0]   sbox [256];
  logic [127:0] rk [15];
  int nr_tb = 10;
  logic [127:0] exp_q [$];
  int launched = 0;
  int done = 0;
  int cancelled = 0;
  bit rand_mode = 1'b0;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    int x = a;
    int y = b;
    int p = 0;
    for (int i = 0; i < 8; i++) begin
      if (y & 1) p = p ^ x;
      x = x << 1;
      if (x & 'h100) x = x ^ 'h11b;
      y = y >> 1;
    end
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    return 8'((v << k) | (v >> (8 - k)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2)
              ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    int nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 15; r++)
      rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    nr_tb = nr;
  endtask

  // Forward cipher: the bench encrypts, the DUT must invert it.
  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int n = 0; n < 16; n++) b[n] = pt[127-8*n -: 8] ^ rk[0][127-8*n -: 8];
    for (int rd = 1; rd <= nr_tb; rd++) begin
      for (int n = 0; n < 16; n++) b[n] = sbox[b[n]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r+4*c] = b[r+4*((c+r)%4)];
      b = t;
      if (rd < nr_tb) begin
        for (int c = 0; c < 4; c++) begin
          a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
          b[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
          b[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
          b[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
          b[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
        end
      end
      for (int n = 0; n < 16; n++) b[n] = b[n] ^ rk[rd][127-8*n -: 8];
    end
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = b[n];
    return o;
  endfunction

  // Monitor + key server: checks address walk, pops scoreboard on ready.
  initial begin
    int seen = 0;
    int cnt = 0;
    bit first = 1'b0;
    bit pv = 1'b0;
    logic [3:0] pa = '0;
    logic [3:0] ea;
    bus.subkey = '0;
    bus.subkey_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (launched != done + cancelled) begin
        if (launched != seen) begin
          seen = launched;
          cnt = 0;
          first = 1'b1;
        end
        cnt++;
        if (bus.ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: ready with empty queue");
          end else begin
            chk("plaintext", bus.plaintext, exp_q.pop_front());
          end
          if (!rand_mode) chk("latency", 128'(cnt - 1), 128'(nr_tb + 1));
          done++;
        end else if (first) begin
          chk("first_addr", 128'(bus.subkey_addr), 128'(nr_tb));
          first = 1'b0;
        end else begin
          ea = pv ? pa - 4'd1 : pa;
          chk("addr_seq", 128'(bus.subkey_addr), 128'(ea));
        end
      end
      pa = bus.subkey_addr;
      bus.subkey = rk[pa];
      pv = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.subkey_valid = pv;
    end
  end

  task automatic launch(input logic [2:0] kl, input logic [127:0] ct,
                        input logic [127:0] exp);
    bus.start = 1'b1;
    bus.key_len = kl;
    bus.ciphertext = ct;
    exp_q.push_back(exp);
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    bus.key_len = 3'($urandom_range(0, 7));
    bus.ciphertext = {$urandom, $urandom, $urandom, $urandom};
    launched++;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done < target && t < 400) begin
      @(posedge clk);
      t++;
    end
    #2;
    if (done < target) begin
      checks++;
      failures++;
      $display("FAIL timeout: done=%0d required %0d", done, target);
    end
  endtask

  task automatic run(input logic [255:0] key, input int nk,
                     input logic [2:0] kl, input logic [127:0] ct,
                     input logic [127:0] exp, input bit rm);
    int tgt;
    rand_mode = rm;
    expand(key, nk);
    tgt = done + 1;
    launch(kl, ct, exp);
    wait_done(tgt);
  endtask

  task automatic check_cleared(input string nm);
    chk({nm, "_ready"}, 128'(bus.ready), 128'd0);
    chk({nm, "_pt"}, bus.plaintext, 128'd0);
    chk({nm, "_addr"}, 128'(bus.subkey_addr), 128'd0);
  endtask

  initial begin
    logic [255:0] k128, k192, k256, key;
    logic [127:0] pt, hold;
    logic [2:0] kls [6];
    int nks [6];
    int idx, tgt;
    kls = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b110, 3'b111};
    nks = '{4, 6, 8, 6, 8, 8};
    k128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    k192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    k256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    build_sbox();
    for (int i = 0; i < 15; i++) rk[i] = '0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.key_len = 3'b000;
    bus.ciphertext = '0;
`ifdef AES_DEC_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #2;
    check_cleared("reset");
    reset = 1'b0;

    run(k128, 4, 3'b001, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT, 0);
    run(k192, 6, 3'b010, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT, 0);
    run(k256, 8, 3'b100, 128'h8ea2b7ca516745bfeafc49904b496089, PT, 1);

    for (int i = 0; i < 8; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      idx = $urandom_range(0, 5);
      expand(key, nks[idx]);
      run(key, nks[idx], kls[idx], encrypt(pt), pt, 1'($urandom_range(0, 1)));
    end

    // key_len=0 start is ignored; result register holds
    hold = bus.plaintext;
    bus.start = 1'b1;
    bus.key_len = 3'b000;
    bus.ciphertext = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("nokey_ready", 128'(bus.ready), 128'd1);
    chk("nokey_pt", bus.plaintext, hold);

    // start pulsed mid-run is ignored
    rand_mode = 1'b0;
    expand(k128, 4);
    tgt = done + 1;
    launch(3'b001, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT);
    repeat (4) @(posedge clk);
    #2;
    bus.start = 1'b1;
    bus.key_len = 3'b100;
    bus.ciphertext = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    wait_done(tgt);

    // reset mid-run, then a fresh run
    launch(3'b001, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT);
    repeat (6) @(posedge clk);
    #2;
    reset = 1'b1;
    cancelled++;
    void'(exp_q.pop_back());
    @(posedge clk);
    #2;
    reset = 1'b0;
    check_cleared("midreset");
    run(k128, 4, 3'b001, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT, 1);

`ifdef AES_DEC_ABORT_EN
    rand_mode = 1'b0;
    launch(3'b001, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT);
    repeat (3) @(posedge clk);
    #2;
    bus.abort = 1'b1;
    cancelled++;
    void'(exp_q.pop_back());
    @(posedge clk);
    #2;
    bus.abort = 1'b0;
    check_cleared("abort");
    tgt = done + 1;
    bus.abort = 1'b1;
    launch(3'b001, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT);
    bus.abort = 1'b0;
    wait_done(tgt);
`endif

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL leftover: %0d entries required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
